// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-fetch request controller: issues word-aligned bus requests, tracks outstanding
// transactions and forwards live responses into the fetch FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no un-granted request held on the bus
// WAIT_GNT | instr_req_o asserted, waiting for instr_gnt_i
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  typedef enum logic {IDLE, WAIT_GNT} state_e;

  localparam int unsigned CW = $clog2(2 * NUM_REQS + 1);

  state_e              state_q, state_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [NUM_REQS-1:0] valid_q, valid_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic [CW-1:0]       outstanding, live_outstanding, fifo_occupied;
  logic [31:0]         branch_waddr;
  logic                new_req, req_out, gnt_push, pushed;

  function automatic logic [CW-1:0] popcnt(input logic [NUM_REQS-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) cnt = cnt + CW'(v[i]);
    return cnt;
  endfunction

  assign outstanding      = popcnt(valid_q);
  assign live_outstanding = popcnt(valid_q & ~discard_q);
  assign fifo_occupied    = popcnt(fifo_busy_i);
  assign branch_waddr     = {addr_i[31:2], 2'b00};

  // A branch bypasses the FIFO-space check because the FIFO is cleared in the same cycle.
  assign new_req  = req_i
                  & (branch_i | ((live_outstanding + fifo_occupied) < CW'(NUM_REQS)))
                  & (outstanding < CW'(NUM_REQS));
  assign req_out  = ~rst_i & (new_req | (state_q == WAIT_GNT));
  assign gnt_push = req_out & instr_gnt_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (new_req & ~instr_gnt_i) state_d = WAIT_GNT;
      WAIT_GNT: if (instr_gnt_i)            state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (branch_i) begin
      fetch_addr_d = gnt_push ? branch_waddr + 32'd4 : branch_waddr;
    end else if (gnt_push) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
    end
  end

  // Pop the oldest entry first, then mark survivors stale on a branch, then push the grant.
  always_comb begin
    valid_d   = valid_q;
    discard_d = discard_q;
    pushed    = 1'b0;
    if (instr_rvalid_i) begin
      for (int i = 0; i < NUM_REQS - 1; i++) begin
        valid_d[i]   = valid_q[i+1];
        discard_d[i] = discard_q[i+1];
      end
      valid_d[NUM_REQS-1]   = 1'b0;
      discard_d[NUM_REQS-1] = 1'b0;
    end
    if (branch_i) discard_d = discard_d | valid_d;
    if (gnt_push) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!pushed && !valid_d[i]) begin
          valid_d[i]   = 1'b1;
          discard_d[i] = 1'b0;
          pushed       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      valid_q      <= '0;
      discard_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      valid_q      <= valid_d;
      discard_q    <= discard_d;
    end
  end

  assign instr_req_o  = req_out;
  assign instr_addr_o = branch_i ? branch_waddr : fetch_addr_q;
  assign fifo_valid_o = ~rst_i & instr_rvalid_i & ~discard_q[0] & ~branch_i;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = req_out | (|valid_q);

`ifndef SYNTHESIS
  a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> valid_q[0]);
  a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (instr_req_o && !instr_gnt_i) |=> (branch_i || $stable(instr_addr_o)));
  a_fifo_space: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_valid_o |-> (!fifo_busy_i[NUM_REQS-1] || fifo_clear_o));
`endif

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Bench for ibex_fetch_req_ctrl: directed scenarios plus a randomized run against an
// epoch-based model of the outstanding bus transactions.
module tb_ibex_fetch_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i, req_i, branch_i;
  logic [31:0] addr_i;
  logic [1:0]  fifo_busy_i;
  logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o, fifo_clear_o, fifo_valid_o, fifo_err_o, instr_req_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o, instr_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .busy_o(busy_o), .fifo_clear_o(fifo_clear_o), .fifo_busy_i(fifo_busy_i),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
    .fifo_err_o(fifo_err_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
  );

  task automatic zero_inputs();
    req_i = 0; branch_i = 0; addr_i = '0; fifo_busy_i = '0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; instr_err_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    zero_inputs();
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    zero_inputs();
    rst_i = 1; req_i = 1;
    #1;
    checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", instr_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", instr_addr_o); end
    instr_rvalid_i = 1; branch_i = 1; addr_i = 32'h40;
    #1;
    checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL rst_fifo_valid: got %b want 0", fifo_valid_o); end
    checks++; if (fifo_clear_o !== 1'b1) begin errors++; $display("FAIL rst_clear: got %b want 1", fifo_clear_o); end
    @(negedge clk_i);
    zero_inputs();
    rst_i = 0;
  endtask

  task automatic test_branch_stream();
    logic [31:0] want_addr [3];
    logic [31:0] data [3];
    want_addr[0] = 32'h80; want_addr[1] = 32'h84; want_addr[2] = 32'h88;
    for (int k = 0; k < 3; k++) data[k] = $urandom;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      req_i = (c < 3); instr_gnt_i = (c < 3);
      branch_i = (c == 0); addr_i = 32'h80;
      instr_rvalid_i = (c > 0); instr_rdata_i = (c > 0) ? data[c-1] : 32'h0;
      #1;
      if (c < 3) begin
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== want_addr[c]) begin errors++;
          $display("FAIL stream_req%0d: got req=%b addr=%h want req=1 addr=%h", c, instr_req_o, instr_addr_o, want_addr[c]); end
      end
      checks++; if (fifo_clear_o !== (c == 0)) begin errors++; $display("FAIL stream_clear%0d: got %b want %b", c, fifo_clear_o, c == 0); end
      if (c > 0) begin
        checks++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== data[c-1]) begin errors++;
          $display("FAIL stream_data%0d: got v=%b d=%h want v=1 d=%h", c, fifo_valid_o, fifo_rdata_o, data[c-1]); end
      end
    end
    @(negedge clk_i);
    zero_inputs();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stream_idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_full();
    int issued;
    do_reset();
    issued = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      req_i = 1; instr_gnt_i = 1;
      #1;
      if (instr_req_o) issued++;
    end
    checks++; if (issued != 2) begin errors++; $display("FAIL full_issued: got %0d want 2", issued); end
    checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL full_req_low: got %b want 0", instr_req_o); end
    @(negedge clk_i);
    instr_rvalid_i = 1;
    #1;
    checks++; if (instr_req_o !== 1'b0 || fifo_valid_o !== 1'b1) begin errors++;
      $display("FAIL full_rvalid_cycle: got req=%b v=%b want req=0 v=1", instr_req_o, fifo_valid_o); end
    issued = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      instr_rvalid_i = 0;
      #1;
      if (instr_req_o) begin
        issued++;
        checks++; if (instr_addr_o !== 32'h8) begin errors++; $display("FAIL full_refill_addr: got %h want 00000008", instr_addr_o); end
      end
    end
    checks++; if (issued != 1) begin errors++; $display("FAIL full_refill_count: got %0d want 1", issued); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1;
    end
    @(negedge clk_i);
    zero_inputs();
  endtask

  task automatic test_gnt_stall();
    logic [31:0] want;
    do_reset();
    @(negedge clk_i);
    req_i = 1; branch_i = 1; addr_i = 32'h80; instr_gnt_i = 1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_i);
      instr_gnt_i = 0; instr_rvalid_i = (s == 0);
      branch_i = (s == 3); addr_i = 32'h202;
      want = (s >= 3) ? 32'h200 : 32'h84;
      #1;
      checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== want) begin errors++;
        $display("FAIL stall%0d: got req=%b addr=%h want req=1 addr=%h", s, instr_req_o, instr_addr_o, want); end
    end
    @(negedge clk_i);
    branch_i = 0; instr_gnt_i = 1;
    #1;
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin errors++;
      $display("FAIL stall_grant: got req=%b addr=%h want req=1 addr=00000200", instr_req_o, instr_addr_o); end
    @(negedge clk_i);
    req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1;
    #1;
    checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL stall_resp: got %b want 1", fifo_valid_o); end
    @(negedge clk_i);
    zero_inputs();
  endtask

  task automatic test_branch_discard();
    do_reset();
    @(negedge clk_i);
    req_i = 1; branch_i = 1; addr_i = 32'h100; instr_gnt_i = 1;
    @(negedge clk_i);
    branch_i = 0;
    #1;
    checks++; if (instr_addr_o !== 32'h104 || instr_req_o !== 1'b1) begin errors++;
      $display("FAIL disc_second: got req=%b addr=%h want req=1 addr=00000104", instr_req_o, instr_addr_o); end
    @(negedge clk_i);
    branch_i = 1; addr_i = 32'h400; instr_rvalid_i = 1;
    #1;
    checks++; if (instr_req_o !== 1'b0 || fifo_valid_o !== 1'b0) begin errors++;
      $display("FAIL disc_full_branch: got req=%b v=%b want req=0 v=0", instr_req_o, fifo_valid_o); end
    @(negedge clk_i);
    branch_i = 0;
    #1;
    checks++; if (fifo_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h400) begin errors++;
      $display("FAIL disc_drop2: got v=%b req=%b addr=%h want v=0 req=1 addr=00000400", fifo_valid_o, instr_req_o, instr_addr_o); end
    @(negedge clk_i);
    req_i = 0; instr_gnt_i = 0;
    #1;
    checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL disc_fwd400: got %b want 1", fifo_valid_o); end
    @(negedge clk_i);
    req_i = 1; instr_gnt_i = 1; instr_rvalid_i = 0;
    @(negedge clk_i);
    branch_i = 1; addr_i = 32'h600;
    #1;
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h600) begin errors++;
      $display("FAIL disc_branch_gnt: got req=%b addr=%h want req=1 addr=00000600", instr_req_o, instr_addr_o); end
    @(negedge clk_i);
    branch_i = 0; req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hdead0404;
    #1;
    checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL disc_drop404: got %b want 0", fifo_valid_o); end
    @(negedge clk_i);
    instr_rdata_i = 32'hcafe0600;
    #1;
    checks++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hcafe0600) begin errors++;
      $display("FAIL disc_fwd600: got v=%b d=%h want v=1 d=cafe0600", fifo_valid_o, fifo_rdata_o); end
    @(negedge clk_i);
    zero_inputs();
  endtask

  task automatic test_fifo_busy();
    do_reset();
    @(negedge clk_i);
    fifo_busy_i = 2'b11; req_i = 1; instr_gnt_i = 1;
    #1;
    checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0) begin errors++;
      $display("FAIL fbusy_block: got req=%b busy=%b want 0 0", instr_req_o, busy_o); end
    @(negedge clk_i);
    branch_i = 1; addr_i = 32'h302;
    #1;
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) begin errors++;
      $display("FAIL fbusy_branch: got req=%b addr=%h want req=1 addr=00000300", instr_req_o, instr_addr_o); end
    @(negedge clk_i);
    branch_i = 0;
    #1;
    checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL fbusy_after: got %b want 0", instr_req_o); end
    @(negedge clk_i);
    fifo_busy_i = 2'b00; req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1;
    #1;
    checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL fbusy_resp: got %b want 1", fifo_valid_o); end
    @(negedge clk_i);
    zero_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk_i);
    req_i = 1; instr_gnt_i = 1;
    @(negedge clk_i);
    instr_gnt_i = 0;
    @(negedge clk_i);
    #1;
    checks++; if (instr_req_o !== 1'b1 || busy_o !== 1'b1) begin errors++;
      $display("FAIL rmid_pre: got req=%b busy=%b want 1 1", instr_req_o, busy_o); end
    rst_i = 1;
    #1;
    checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0) begin errors++;
      $display("FAIL rmid_drop: got req=%b busy=%b want 0 0", instr_req_o, busy_o); end
    @(negedge clk_i);
    req_i = 0; rst_i = 0;
    #1;
    checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0 || instr_addr_o !== 32'h0) begin errors++;
      $display("FAIL rmid_idle: got req=%b busy=%b addr=%h want 0 0 0", instr_req_o, busy_o, instr_addr_o); end
  endtask

  // Model: each bus transaction records the branch epoch it was issued in; a response is
  // forwarded only if its epoch is still current and no branch is happening right now.
  task automatic test_random();
    logic [31:0] q_addr[$];
    int unsigned q_epoch[$];
    int unsigned epoch, n_live;
    logic [31:0] next_addr, exp_addr, data;
    logic waiting, exp_req, exp_fv, exp_busy, allow, r, b, g, e;
    logic [31:0] tgt;
    logic [1:0] fb;
    int occ;
    do_reset();
    epoch = 0; next_addr = 0; waiting = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      r = (q_addr.size() > 0) && ($urandom_range(2) == 0);
      b = ($urandom_range(5) == 0);
      g = $urandom_range(1);
      e = $urandom_range(1);
      fb = 2'($urandom_range(3));
      tgt = {$urandom, 1'b0};
      data = $urandom;
      exp_fv = r && (q_epoch[0] == epoch) && !b;
      if (exp_fv) fb[1] = 1'b0;
      occ = int'(fb[0]) + int'(fb[1]);
      n_live = 0;
      foreach (q_epoch[k]) if (q_epoch[k] == epoch) n_live++;
      req_i = ($urandom_range(3) != 0); branch_i = b; addr_i = tgt; fifo_busy_i = fb;
      instr_gnt_i = g; instr_rvalid_i = r; instr_rdata_i = data; instr_err_i = e;
      allow = req_i && (b || (int'(n_live) + occ < 2)) && (q_addr.size() < 2);
      exp_req = allow || waiting;
      exp_addr = b ? (tgt & 32'hffff_fffc) : next_addr;
      exp_busy = exp_req || (q_addr.size() > 0);
      #1;
      checks++; if (instr_req_o !== exp_req || busy_o !== exp_busy) begin errors++;
        $display("FAIL rnd_req c%0d: got req=%b busy=%b want req=%b busy=%b", c, instr_req_o, busy_o, exp_req, exp_busy); end
      checks++; if (instr_addr_o !== exp_addr) begin errors++;
        $display("FAIL rnd_addr c%0d: got %h want %h", c, instr_addr_o, exp_addr); end
      checks++; if (fifo_valid_o !== exp_fv || fifo_rdata_o !== data || fifo_err_o !== e || fifo_clear_o !== b || fifo_addr_o !== tgt) begin errors++;
        $display("FAIL rnd_fifo c%0d: got v=%b d=%h e=%b clr=%b want v=%b d=%h e=%b clr=%b", c, fifo_valid_o, fifo_rdata_o, fifo_err_o, fifo_clear_o, exp_fv, data, e, b); end
      if (r) begin void'(q_addr.pop_front()); void'(q_epoch.pop_front()); end
      if (b) epoch++;
      if (exp_req && g) begin
        q_addr.push_back(exp_addr); q_epoch.push_back(epoch);
        next_addr = exp_addr + 32'd4; waiting = 0;
      end else if (exp_req) begin
        next_addr = exp_addr; waiting = 1;
      end else if (b) begin
        next_addr = tgt & 32'hffff_fffc;
      end
    end
    @(negedge clk_i);
    zero_inputs();
  endtask

  initial begin
    zero_inputs();
    rst_i = 1;
    test_reset();
    test_branch_stream();
    test_full();
    test_gnt_stall();
    test_branch_discard();
    test_fifo_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
